// File: rtl/imem_pkg.sv
// Constants, loader state encoding and instruction field decode shared by the
// instruction memory, imem_loader and the benches.
package imem_pkg;

    localparam int IMEM_DEPTH     = 16;
    localparam int IMEM_WORD_W    = 32;
    localparam int BYTES_PER_WORD = IMEM_WORD_W / 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } ld_state_t;

    function automatic logic [5:0] f_opcode(input logic [31:0] w);
        return w[31:26];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] w);
        return w[25:21];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] w);
        return w[20:16];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] w);
        return w[15:11];
    endfunction

    function automatic logic [4:0] f_sa(input logic [31:0] w);
        return w[10:6];
    endfunction

    function automatic logic [5:0] f_func(input logic [31:0] w);
        return w[5:0];
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Byte-to-word assembler: MSB-first shift register with a byte counter.
// full is high while the next load completes the current word.
module word_packer #(
    parameter int tam = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           load,
    input  logic [7:0]     in_byte,
    output logic [tam-1:0] word,
    output logic           full
);

    localparam int bpw = tam / 8;
    localparam int cw  = (bpw > 1) ? $clog2(bpw) : 1;
    localparam logic [cw-1:0] last = cw'(bpw - 1);

    logic [cw-1:0] cnt;

    assign full = (cnt == last);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word <= '0;
            cnt  <= '0;
        end else if (load) begin
            word <= (word << 8) | tam'(in_byte);
            cnt  <= full ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into the instruction memory write port, one word per 4 bytes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
    import imem_pkg::*;
#(
    parameter int tam    = IMEM_WORD_W,
    parameter int depth  = IMEM_DEPTH,
    parameter int addr_w = $clog2(depth)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [addr_w-1:0] mem_addr,
    output logic [tam-1:0]    mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [addr_w-1:0] last_addr = addr_w'(depth - 1);

    ld_state_t         state;
    logic [addr_w-1:0] addr;
    logic [tam-1:0]    word;
    logic              pk_full;
    logic              pk_load;
    logic              pk_clear;

    // Every output is a decode of the state register or a register itself,
    // so in_ready never depends on in_valid combinationally.
    assign in_ready  = (state == RECV) || (state == CHECK);
    assign mem_we    = (state == WRITE);
    assign busy      = (state == RECV) || (state == WRITE) || (state == CHECK);
    assign done      = (state == DONE);
    assign mem_addr  = addr;
    assign mem_wdata = word;

    assign pk_load  = (state == RECV) && in_valid;
    assign pk_clear = start && ((state == IDLE) || (state == DONE));

    word_packer #(.tam(tam)) u_packer (
        .clk     (clk),
        .reset   (reset),
        .clear   (pk_clear),
        .load    (pk_load),
        .in_byte (in_byte),
        .word    (word),
        .full    (pk_full)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] acc;
    logic       err_q;

    assign err = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            addr  <= '0;
            acc   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state <= RECV;
                    addr  <= '0;
                    acc   <= '0;
                    err_q <= 1'b0;
                end
                RECV: if (in_valid) begin
                    acc <= acc ^ in_byte;
                    if (pk_full) state <= WRITE;
                end
                WRITE: if (addr == last_addr) begin
                    state <= CHECK;
                end else begin
                    addr  <= addr + 1'b1;
                    state <= RECV;
                end
                CHECK: if (in_valid) begin
                    err_q <= (in_byte != acc);
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign err = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            addr  <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state <= RECV;
                    addr  <= '0;
                end
                RECV: if (in_valid && pk_full) state <= WRITE;
                WRITE: if (addr == last_addr) begin
                    state <= DONE;
                end else begin
                    addr  <= addr + 1'b1;
                    state <= RECV;
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: byte-level driver, write monitor and a
// word-list reference built from the byte stream.
module tb_imem_loader;
    import imem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, mem_we, busy, done, err;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;

    int ntests = 0;
    int nfail  = 0;

    logic [7:0]  bq [64];
    logic [35:0] wq [$];

    always #5 clk = ~clk;

    imem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: records every write and checks the WRITE bubble.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wq.push_back({mem_addr, mem_wdata});
            chk("we_rdy", {63'd0, in_ready}, 64'd0);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer a byte after optional random idle cycles; returns at the negedge
    // following the accepting edge.
    task automatic send(input logic [7:0] b, input int gap_pct);
        int t = 0;
        while ($urandom_range(0, 99) < gap_pct) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("rdy_timeout", 64'd0, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_byte  = $urandom();
    endtask

    task automatic run_load(input string tag, input int gap_pct, input bit bad_ck,
                            input int pulse_at);
        logic [7:0]  x = 8'h00;
        logic [31:0] w;
        wq.delete();
        pulse_start();
        chk({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 64; i++) begin
            if (i == pulse_at) pulse_start();
            send(bq[i], gap_pct);
            x ^= bq[i];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(bad_ck ? (x ^ 8'h5a) : x, gap_pct);
        chk({tag, "_err"}, {63'd0, err}, {63'd0, bad_ck});
`else
        @(negedge clk);
        chk({tag, "_err"}, {63'd0, err}, 64'd0);
`endif
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        repeat (5) @(negedge clk);
        chk({tag, "_nwr"}, 64'(wq.size()), 64'd16);
        for (int k = 0; k < 16 && k < wq.size(); k++) begin
            w = {bq[4*k], bq[4*k+1], bq[4*k+2], bq[4*k+3]};
            chk({tag, "_wr"}, 64'(wq[k]), 64'({k[3:0], w}));
        end
    endtask

    initial begin
        logic [31:0] w0;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_rdy",  {63'd0, in_ready}, 64'd0);
        chk("rst_we",   {63'd0, mem_we},   64'd0);
        chk("rst_addr", 64'(mem_addr),     64'd0);
        chk("rst_data", 64'(mem_wdata),    64'd0);
        chk("rst_busy", {63'd0, busy},     64'd0);
        chk("rst_done", {63'd0, done},     64'd0);
        chk("rst_err",  {63'd0, err},      64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_rdy", {63'd0, in_ready}, 64'd0);

        // basic word and field decode
        wq.delete();
        pulse_start();
        chk("bas_rdy", {63'd0, in_ready}, 64'd1);
        send(8'h00, 0); send(8'h23, 0); send(8'h10, 0); send(8'h21, 0);
        chk("bas_we",   {63'd0, mem_we}, 64'd1);
        chk("bas_addr", 64'(mem_addr),   64'd0);
        chk("bas_data", 64'(mem_wdata),  64'h00231021);
        w0 = mem_wdata;
        chk("bas_op",   64'(f_opcode(w0)), 64'd0);
        chk("bas_rd",   64'(f_rd(w0)),     64'd1);
        chk("bas_rs",   64'(f_rs(w0)),     64'd3);
        chk("bas_rt",   64'(f_rt(w0)),     64'd2);
        chk("bas_sa",   64'(f_sa(w0)),     64'd0);
        chk("bas_func", 64'(f_func(w0)),   64'h21);
        @(negedge clk);
        chk("bas_bubble", {63'd0, in_ready}, 64'd1);

        // reset mid-word 3
        reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
        for (int i = 0; i < 64; i++) bq[i] = $urandom();
        wq.delete();
        pulse_start();
        for (int i = 0; i < 14; i++) send(bq[i], 30);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mr_rdy",  {63'd0, in_ready}, 64'd0);
        chk("mr_we",   {63'd0, mem_we},   64'd0);
        chk("mr_addr", 64'(mem_addr),     64'd0);
        chk("mr_data", 64'(mem_wdata),    64'd0);
        chk("mr_busy", {63'd0, busy},     64'd0);
        chk("mr_done", {63'd0, done},     64'd0);
        repeat (3) @(negedge clk);
        chk("mr_nwr", 64'(wq.size()), 64'd3);
        wq.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) send(bq[i + 20], 0);
        chk("mr_re_we",   {63'd0, mem_we}, 64'd1);
        chk("mr_re_addr", 64'(mem_addr),   64'd0);
        chk("mr_re_data", 64'(mem_wdata),  64'({bq[20], bq[21], bq[22], bq[23]}));
        reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);

        // full load, words 0x000000kk, gap-free
        for (int k = 0; k < 16; k++) begin
            bq[4*k] = 8'h00; bq[4*k+1] = 8'h00; bq[4*k+2] = 8'h00; bq[4*k+3] = 8'(k);
        end
        run_load("full", 0, 1'b0, -1);

        // random data with random in_valid gaps, twice
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 64; i++) bq[i] = $urandom();
            run_load("gap", 40, 1'b0, -1);
        end

        // start pulsed mid-load is ignored; start in DONE restarts at addr 0
        for (int i = 0; i < 64; i++) bq[i] = $urandom();
        run_load("istart", 20, 1'b0, 22);
        wq.delete();
        pulse_start();
        chk("rs_done", {63'd0, done},     64'd0);
        chk("rs_rdy",  {63'd0, in_ready}, 64'd1);
        chk("rs_busy", {63'd0, busy},     64'd1);
        for (int i = 0; i < 4; i++) send(bq[i + 8], 0);
        chk("rs_addr", 64'(mem_addr),  64'd0);
        chk("rs_data", 64'(mem_wdata), 64'({bq[8], bq[9], bq[10], bq[11]}));

`ifdef IMEM_LOADER_CHECKSUM_EN
        reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
        for (int i = 0; i < 64; i++) bq[i] = $urandom();
        run_load("ck_bad", 25, 1'b1, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
